// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch program counter with trap/flush redirect, stall hold,
// misaligned-target rejection and a circular return-address stack.
module pc_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     IALIGN       = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       stall_i,
    input  logic                       flush_valid_i,
    input  logic [XLEN-1:0]            flush_target_i,
    input  logic                       trap_i,
    input  logic [XLEN-1:0]            trap_vector_i,
    input  logic                       call_i,
    input  logic                       ret_i,
    output logic [XLEN-1:0]            pc_out_o,
    output logic [XLEN-1:0]            pc_next_seq_o,
    output logic                       redirected_o,
    output logic                       misaligned_err_o,
    output logic [$clog2(RAS_DEPTH):0] ras_count_o
);
    localparam int unsigned PW   = $clog2(RAS_DEPTH);
    localparam int unsigned AW   = $clog2(IALIGN);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d, seq, tgt;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   wp_q, wp_d, top, wr_idx;
    logic [PW:0]     cnt_q, cnt_d;
    logic            redir_q, redir_d, mis_q, mis_d;
    logic            tgt_mis, adv, pop, push, repl;

    assign seq     = pc_q + XLEN'(IALIGN);
    assign tgt     = trap_i ? trap_vector_i : flush_target_i;
    assign tgt_mis = |tgt[AW-1:0];
    assign top     = wp_q - PW'(1);
    // adv: no trap/flush/stall, so the RAS may act this cycle
    assign adv     = !trap_i && !flush_valid_i && !stall_i;
    assign pop     = adv && ret_i && cnt_q != '0;
    assign repl    = pop && call_i;
    assign push    = adv && call_i && !ret_i;
    assign wr_idx  = push ? wp_q : top;

    always_comb begin
        pc_d    = pc_q;
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        redir_d = 1'b0;
        mis_d   = 1'b0;
        if (trap_i || flush_valid_i) begin
            pc_d    = tgt_mis ? pc_q : tgt;
            redir_d = !tgt_mis;
            mis_d   = tgt_mis;
            wp_d    = trap_i ? '0 : wp_q;
            cnt_d   = trap_i ? '0 : cnt_q;
        end else if (!stall_i) begin
            pc_d    = pop ? ras_q[top] : seq;
            redir_d = pop;
            wp_d    = push ? wp_q + PW'(1) : (pop && !call_i) ? top : wp_q;
            cnt_d   = push ? ((cnt_q == FULL) ? cnt_q : cnt_q + 1'b1)
                    : (pop && !call_i) ? cnt_q - 1'b1 : cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q    <= RESET_VECTOR;
            wp_q    <= '0;
            cnt_q   <= '0;
            redir_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
            redir_q <= redir_d;
            mis_q   <= mis_d;
        end
    end

    // entries need no reset: ras_count gates every read
    always_ff @(posedge clk_i) begin
        if (push || repl) ras_q[wr_idx] <= seq;
    end

    assign pc_out_o         = pc_q;
    assign pc_next_seq_o    = seq;
    assign redirected_o     = redir_q;
    assign misaligned_err_o = mis_q;
    assign ras_count_o      = cnt_q;
endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter controller for the base CPU fetch stage, successor to the single-register PC. It holds the fetch PC and selects the next PC each cycle from the following sources, in priority order: reset, trap, pipeline redirect, stall hold, return-address-stack prediction, and sequential increment. It also detects misaligned redirect targets and keeps a small circular return-address stack (RAS) so that `ret` can be fetched without a bubble.

## Interface
Parameters:
- `XLEN`, 32: PC and target width.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded by reset.
- `IALIGN`, 4: instruction alignment and sequential step in bytes. Legal values are 2 and 4.
- `RAS_DEPTH`, 4: number of RAS entries. Must be a power of two, ≥2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `stall`, in, 1: hold the PC. Suppresses push and pop.
- `flush_valid`, in, 1: redirect from execute (branch or jump resolved).
- `flush_target`, in, XLEN: redirect address.
- `trap`, in, 1: exception or interrupt entry.
- `trap_vector`, in, XLEN: trap handler address.
- `call`, in, 1: the instruction at `pc_out` is a call. Push `pc_out+IALIGN`.
- `ret`, in, 1: the instruction at `pc_out` is a return. Predict from the RAS top.
- `pc_out`, out, XLEN: current fetch PC (registered).
- `pc_next_seq`, out, XLEN: `pc_out + IALIGN` (combinational).
- `redirected`, out, 1: registered. High for one cycle after the PC was loaded from trap, flush or RAS.
- `misaligned_err`, out, 1: registered. High for one cycle after a misaligned flush or trap target was rejected.
- `ras_count`, out, $clog2(RAS_DEPTH)+1: number of valid RAS entries.

## Operation
- Reset, while asserted on a clock edge:
  - `pc_out`=RESET_VECTOR
  - RAS pointer and `ras_count`=0
  - `redirected`=0
  - `misaligned_err`=0
- Next-PC selection, first match wins:
  1. `trap`: load `trap_vector`. Clear the RAS (`ras_count`=0, pointer=0). Ignore `call`, `ret` and `stall`.
  2. `flush_valid`: load `flush_target`. The RAS is untouched. Ignore `call`, `ret` and `stall`.
  3. `stall`: hold `pc_out`. No push, no pop.
  4. `ret` with `ras_count`>0: load the RAS top and pop. If `call` is also asserted, the top entry is replaced with `pc_out+IALIGN` and `ras_count` is unchanged.
  5. `ret` with `ras_count`=0: sequential step. No pop, no redirect.
  6. Otherwise: `pc_out + IALIGN`. If `call` is asserted, push `pc_out+IALIGN`.
- Misalignment check, applied to trap and flush targets:
  - A target is misaligned if `target % IALIGN != 0` (bit 1:0 nonzero for 4; bit 0 for 2).
  - On a misaligned target: `pc_out` holds, `misaligned_err`=1 next cycle, `redirected`=0. For a trap, the RAS is still cleared.
  - RAS entries are always aligned and need no check.
- RAS:
  - Circular buffer with a write pointer.
  - Push when full overwrites the oldest entry. `ras_count` saturates at RAS_DEPTH.
  - A pop after an overflow still returns entries in LIFO order. The oldest entries are lost.
- Arithmetic is modulo 2^XLEN. Sequential increment from the top of the address space wraps to 0 without a flag.

## Timing
- Single-cycle update: the input sampled at edge N is reflected on `pc_out` after edge N.
- `redirected` and `misaligned_err` are registered. Each is valid the cycle after the event and self-clears unless the event repeats.
- `pc_next_seq` is purely combinational from `pc_out`.
- There is no stall bubble. `stall` held for k cycles holds `pc_out` for exactly k cycles.
- Reset asserted mid-stall, mid-redirect or with `trap` asserted: reset wins, and all state returns to reset values on that edge.
- Trap and flush asserted together: the trap target is used and the flush is discarded.

## Test plan
- **Reset and sequential run.** RESET_VECTOR=0, IALIGN=4. Release reset. `pc_out` must step 0→4→8→C on consecutive edges, with `redirected`=0 throughout.
- **Stall vs. flush.** From 0x10, assert `stall` for 2 cycles: `pc_out` holds 0x10. On the next cycle assert `stall`+`flush_valid` with target 0x80: `pc_out`=0x80, then `redirected`=1 for one cycle.
- **Call/return.** `call` at 0x20 and `call` at 0x40, then `ret` at 0x100. `pc_out` must become 0x44 and `ras_count` must go 2→1. A second `ret` gives 0x24 and `ras_count`=0. A third `ret` falls through sequentially.
- **RAS overflow.** RAS_DEPTH=4. Perform 5 calls, pushing A..E. `ras_count` stays at 4. Four `ret`s yield E, D, C, B. The fifth `ret` is sequential.
- **Misaligned flush.** Flush to 0x102 with IALIGN=4: `pc_out` holds, then `misaligned_err`=1 for one cycle. Repeat with IALIGN=2: accepted, `pc_out`=0x102.
- **Trap priority.** Trap to 0x200 in the same cycle as a flush to 0x80 and `ret` with 3 RAS entries. Result: `pc_out`=0x200, `ras_count`=0, `redirected`=1. Then assert `reset` in the following cycle: `pc_out`=RESET_VECTOR and both flags are 0.
